bram_read_sched: RTL and testbench

Read scheduler that shares the single read port of the 1024x8 sample/weight block RAM between two burst requesters: the input-feature fetch (req0) and the weight fetch (req1). It arbitrates round-robin at burst boundaries and generates the BRAM address/enable sequence. It also absorbs the BRAM read latency and streams the returned bytes to the neuron datapath over a valid/ready interface with full backpressure.

---
 rtl/bram_read_sched.sv | 202 ++++++++++++++++++++
 tb/tb_bram_read_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_read_sched.sv
// bram_read_sched
//
// Shares the single read port of the 1024x8 sample/weight block RAM between
// two burst requesters: input-feature fetch (req0) and weight fetch (req1).
// Grants are round-robin at burst boundaries. The block drives the BRAM
// address/enable sequence, absorbs the BRAM read latency in a small return
// FIFO, and streams the bytes out with full backpressure.
//
// Build option: define BRAM_OREG_EN when the BRAM output register is enabled
// (read latency 2). Without it the read latency is 1.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   i_reqN_valid/addr/len    burst request N (len = beats minus one)
//   o_reqN_ready             one-cycle accept pulse for requester N
//   o_mem_en, o_mem_addr     BRAM read enable / address
//   i_mem_dout               BRAM read data, valid LAT cycles after o_mem_en
//   o_out_valid/i_out_ready  output stream handshake
//   o_out_data/last/id       stream byte, final-beat flag, owning requester
//   o_busy                   high whenever a burst is being served
//   o_dbg_state              current FSM state (0 idle, 1 burst, 2 drain)
//
// Handshake: a beat transfers in a cycle where o_out_valid && i_out_ready.
// Once o_out_valid is high it stays high, with data/last/id stable, until
// that transfer. A request is accepted in the cycle its o_reqN_ready is high;
// the requester holds valid/addr/len until then.

module bram_read_sched #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req0_valid,
  input  logic [AW-1:0] i_req0_addr,
  input  logic [AW-1:0] i_req0_len,
  output logic          o_req0_ready,
  input  logic          i_req1_valid,
  input  logic [AW-1:0] i_req1_addr,
  input  logic [AW-1:0] i_req1_len,
  output logic          o_req1_ready,
  output logic          o_mem_en,
  output logic [AW-1:0] o_mem_addr,
  input  logic [DW-1:0] i_mem_dout,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [DW-1:0] o_out_data,
  output logic          o_out_last,
  output logic          o_out_id,
  output logic          o_busy,
  output logic [1:0]    o_dbg_state
);

`ifdef BRAM_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  // Two extra slots over the read latency let the stream run at one beat
  // per cycle while the credit check still guarantees no overflow.
  localparam int DEPTH = LAT + 2;
  localparam int PW    = 2;
  localparam int CW    = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_len;
  logic          r_id;
  logic          r_last_grant;
  logic [AW:0]   r_issue_cnt;
  logic [AW:0]   r_beat_cnt;
  logic [LAT-1:0] r_pipe;
  logic [DW-1:0] r_fifo [0:DEPTH-1];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_grant0;
  logic          w_grant1;
  logic [CW-1:0] w_inflight;
  logic          w_credit;
  logic          w_issue;
  logic          w_issue_done;
  logic          w_push;
  logic          w_out_valid;
  logic          w_pop;
  logic          w_last_beat;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // On a tie the requester that was not granted last wins; r_last_grant
  // resets to 1 so req0 wins the first tie. Gated by rst so no accept is
  // signalled in a cycle that is about to be discarded.
  assign w_grant0 = (r_state == S_IDLE) && !rst && i_req0_valid &&
                    (!i_req1_valid || r_last_grant);
  assign w_grant1 = (r_state == S_IDLE) && !rst && i_req1_valid &&
                    (!i_req0_valid || !r_last_grant);

  // Reads still in the BRAM pipeline, each tagged by one r_pipe bit.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      w_inflight = w_inflight + CW'(r_pipe[i]);
    end
  end

  // Only issue when every outstanding read is guaranteed a FIFO slot.
  assign w_credit     = ({1'b0, r_count} + {1'b0, w_inflight}) < (CW + 1)'(DEPTH);
  assign w_issue      = (r_state == S_BURST) && w_credit;
  assign w_issue_done = w_issue && (r_issue_cnt == {1'b0, r_len});
  assign w_push       = r_pipe[LAT-1];
  assign w_out_valid  = (r_count != '0);
  assign w_pop        = w_out_valid && i_out_ready;
  assign w_last_beat  = w_out_valid && (r_beat_cnt == {1'b0, r_len});

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant0 || w_grant1) w_next = S_BURST;
      S_BURST: if (w_issue_done) w_next = S_DRAIN;
      S_DRAIN: if (w_pop && w_last_beat) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_len        <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_issue_cnt  <= '0;
      r_beat_cnt   <= '0;
      r_pipe       <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_state <= w_next;

      if (w_grant0 || w_grant1) begin
        r_addr       <= w_grant1 ? i_req1_addr : i_req0_addr;
        r_len        <= w_grant1 ? i_req1_len  : i_req0_len;
        r_id         <= w_grant1;
        r_last_grant <= w_grant1;
        r_issue_cnt  <= '0;
      end else if (w_issue) begin
        r_addr      <= r_addr + AW'(1);
        r_issue_cnt <= r_issue_cnt + (AW + 1)'(1);
      end

      // The FIFO is empty whenever a grant happens, so these never coincide.
      if (w_grant0 || w_grant1) begin
        r_beat_cnt <= '0;
      end else if (w_pop) begin
        r_beat_cnt <= r_beat_cnt + (AW + 1)'(1);
      end

      r_pipe[0] <= w_issue;
      for (int i = 1; i < LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end

      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Return data storage needs no reset; r_count decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= i_mem_dout;
  end

  assign o_req0_ready = w_grant0;
  assign o_req1_ready = w_grant1;
  assign o_mem_en     = w_issue;
  assign o_mem_addr   = r_addr;
  assign o_out_valid  = w_out_valid;
  assign o_out_data   = w_out_valid ? r_fifo[r_rd_ptr] : '0;
  assign o_out_last   = w_last_beat;
  assign o_out_id     = r_id;
  assign o_busy       = (r_state != S_IDLE);
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_bram_read_sched.sv
module tb_bram_read_sched;

`ifdef BRAM_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = LAT + 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       req0_valid, req1_valid;
  logic [9:0] req0_addr, req0_len, req1_addr, req1_len;
  logic       req0_ready, req1_ready;
  logic       mem_en;
  logic [9:0] mem_addr;
  logic [7:0] mem_dout;
  logic       out_valid, out_ready, out_last, out_id, busy;
  logic [7:0] out_data;
  logic [1:0] dbg_state;

  bram_read_sched #(.AW(10), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .i_req0_valid(req0_valid), .i_req0_addr(req0_addr), .i_req0_len(req0_len),
    .o_req0_ready(req0_ready),
    .i_req1_valid(req1_valid), .i_req1_addr(req1_addr), .i_req1_len(req1_len),
    .o_req1_ready(req1_ready),
    .o_mem_en(mem_en), .o_mem_addr(mem_addr), .i_mem_dout(mem_dout),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_out_last(out_last), .o_out_id(out_id), .o_busy(busy),
    .o_dbg_state(dbg_state)
  );

  // ---------------- BRAM model ----------------
  logic [7:0] mem [1024];
  logic [7:0] bram_q1, bram_q2;
  always @(posedge clk) begin
    if (mem_en) bram_q1 <= mem[mem_addr];
    bram_q2 <= bram_q1;
  end
  assign mem_dout = (LAT == 2) ? bram_q2 : bram_q1;

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [9:0] exp_q[$];       // {id, last, data}
  logic [9:0] exp_addr_q[$];
  int         grant_log[$];
  int         outstanding = 0;
  bit         model_last = 1'b1;
  bit         want_en = 1'b0, want_val = 1'b0;
  int         acc_cyc = 0, first_hs = 0, span = 0, hs_idx = 0, beats_seen = 0;
  logic       prev_valid = 1'b0, prev_ready = 1'b0;
  logic [9:0] prev_beat = '0;
  int         win, g_id, ai;
  logic [9:0] g_addr, g_len, e;
  bit         rand_mode = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      exp_addr_q.delete();
      model_last  = 1'b1;
      outstanding = 0;
      prev_valid  = 1'b0;
      want_en     = 1'b0;
      want_val    = 1'b0;
    end else begin
      if (req0_ready || req1_ready) begin
        check("one_grant", req0_ready && req1_ready, 0);
        if (req0_valid && req1_valid) win = model_last ? 0 : 1;
        else win = req1_valid ? 1 : 0;
        check("grant_id", req1_ready, win);
        check("grant_valid", req1_ready ? req1_valid : req0_valid, 1);
        check("grant_idle", busy, 0);
        model_last = (win == 1);
        g_id   = req1_ready ? 1 : 0;
        g_addr = req1_ready ? req1_addr : req0_addr;
        g_len  = req1_ready ? req1_len : req0_len;
        grant_log.push_back(g_id);
        for (int i = 0; i <= int'(g_len); i++) begin
          ai = (int'(g_addr) + i) % 1024;
          exp_addr_q.push_back(10'(ai));
          exp_q.push_back({g_id[0], (i == int'(g_len)), mem[ai]});
        end
        acc_cyc  = cyc;
        want_en  = 1'b1;
        want_val = 1'b1;
        hs_idx   = 0;
      end

      if (mem_en) begin
        if (want_en) begin
          check("first_en_lat", cyc - acc_cyc, 1);
          want_en = 1'b0;
        end
        check("issue_credit", outstanding < DEPTH, 1);
        if (exp_addr_q.size() == 0) check("issue_expected", 0, 1);
        else check("mem_addr", mem_addr, exp_addr_q.pop_front());
      end

      if (out_valid && want_val) begin
        check("first_valid_lat", cyc - acc_cyc, LAT + 2);
        want_val = 1'b0;
      end

      if (prev_valid && !prev_ready) begin
        check("hold_valid", out_valid, 1);
        check("hold_beat", {out_id, out_last, out_data}, prev_beat);
      end

      if (!out_valid && out_last) check("last_needs_valid", out_last, 0);

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("beat_expected", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check("beat", {out_id, out_last, out_data}, e);
          if (hs_idx == 0) first_hs = cyc;
          if (e[8]) span = cyc - first_hs;
        end
        hs_idx++;
        beats_seen++;
      end

      if (mem_en) outstanding++;
      if (out_valid && out_ready) outstanding--;
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_beat  = {out_id, out_last, out_data};
    end
  end

  // ---------------- drivers ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Presents n0 requests on req0 and n1 on req1, holding each until accepted.
  // Called and returns #1 after a rising edge.
  task automatic drive_reqs(input int n0, input logic [9:0] a0, input logic [9:0] l0,
                            input int n1, input logic [9:0] a1, input logic [9:0] l1);
    int c0, c1, guard;
    c0 = n0; c1 = n1; guard = 0;
    req0_addr = a0; req0_len = l0; req1_addr = a1; req1_len = l1;
    req0_valid = (c0 > 0);
    req1_valid = (c1 > 0);
    while ((c0 > 0 || c1 > 0) && guard < 20000) begin
      @(negedge clk);
      if (req0_ready) c0--;
      if (req1_ready) c1--;
      @(posedge clk);
      #1;
      req0_valid = (c0 > 0);
      req1_valid = (c1 > 0);
      guard++;
    end
    if (guard >= 20000) check("req_timeout", 0, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while ((busy || exp_q.size() != 0) && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 5000) check("done_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    @(negedge clk);
    check({pfx, "_mem_en"}, mem_en, 0);
    check({pfx, "_mem_addr"}, mem_addr, 0);
    check({pfx, "_req0_ready"}, req0_ready, 0);
    check({pfx, "_req1_ready"}, req1_ready, 0);
    check({pfx, "_out_valid"}, out_valid, 0);
    check({pfx, "_out_last"}, out_last, 0);
    check({pfx, "_out_id"}, out_id, 0);
    check({pfx, "_out_data"}, out_data, 0);
    check({pfx, "_busy"}, busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, gbase, g, n0, n1;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = '0; req0_len = '0; req1_addr = '0; req1_len = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);

    repeat (3) @(posedge clk);
    check_reset_outputs("rst0");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Tie arbitration straight out of reset: expect 0,1,0,1.
    gbase = grant_log.size();
    drive_reqs(2, 10'h100, 10'd0, 2, 10'h200, 10'd0);
    wait_done();
    check("tie_grants", grant_log.size() - gbase, 4);
    if (grant_log.size() - gbase == 4) begin
      for (int i = 0; i < 4; i++) check("tie_order", grant_log[gbase + i], i % 2);
    end

    // Single burst, req0 at 0x010, 4 beats.
    base = beats_seen;
    drive_reqs(1, 10'h010, 10'd3, 0, 10'h0, 10'd0);
    wait_done();
    check("single_beats", beats_seen - base, 4);
    check("single_span", span, 3);

    // Address wrap on req1.
    base = beats_seen;
    drive_reqs(0, 10'h0, 10'd0, 1, 10'h3FE, 10'd3);
    wait_done();
    check("wrap_beats", beats_seen - base, 4);
    check("wrap_span", span, 3);

    // Backpressure with random out_ready.
    rand_mode = 1'b1;
    base = beats_seen;
    drive_reqs(1, 10'($urandom_range(0, 1023)), 10'd15, 0, 10'h0, 10'd0);
    wait_done();
    check("bp_beats", beats_seen - base, 16);
    rand_mode = 1'b0;

    // Full length burst.
    base = beats_seen;
    drive_reqs(1, 10'($urandom_range(0, 1023)), 10'd1023, 0, 10'h0, 10'd0);
    wait_done();
    check("full_beats", beats_seen - base, 1024);
    check("full_span", span, 1023);

    // Random mixed traffic.
    for (int r = 0; r < 6; r++) begin
      n0 = $urandom_range(0, 2);
      n1 = $urandom_range(0, 2);
      if (n0 + n1 == 0) n0 = 1;
      rand_mode = 1'($urandom_range(0, 1));
      base = beats_seen;
      drive_reqs(n0, 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 20)),
                 n1, 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 20)));
      wait_done();
      check("mix_done", exp_q.size(), 0);
    end
    rand_mode = 1'b0;

    // Reset in the cycle of the 5th beat of a 32-beat burst.
    base = beats_seen;
    drive_reqs(1, 10'($urandom_range(0, 1023)), 10'd31, 0, 10'h0, 10'd0);
    g = 0;
    while (beats_seen - base < 4 && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("mid_reset_reached", beats_seen - base, 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("rst_mid");
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      check("no_stale_valid", out_valid, 0);
    end
    @(posedge clk);
    #1;

    // Clean restart; tie again so req0 must win after the pointer reset.
    gbase = grant_log.size();
    base  = beats_seen;
    drive_reqs(1, 10'($urandom_range(0, 1023)), 10'd7, 1, 10'($urandom_range(0, 1023)), 10'd2);
    wait_done();
    check("post_rst_beats", beats_seen - base, 11);
    if (grant_log.size() - gbase == 2) check("post_rst_first", grant_log[gbase], 0);
    else check("post_rst_grants", grant_log.size() - gbase, 2);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_err);
    $fatal(1, "simulation timeout");
  end

endmodule
